// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Transmit end of the keypad-to-checker button interface. Scans a
//             4x4 active-low matrix keypad one column at a time, debounces
//             whole-keypad scan results and encodes one accepted key at a time
//             onto button. bstate is high while the accepted key is held; the
//             downstream checker samples button on the falling edge of bstate.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SCAN_DIV        hwclk cycles per column dwell (>= 4)
//    DEBOUNCE_SCANS  consecutive identical full scans to accept press/release (>= 1)
//  Ports
//    hwclk      in   1  system clock, all logic on posedge
//    reset      in   1  asynchronous active-high reset
//    row_in     in   4  keypad rows, active-low, asynchronous to hwclk
//    col_out    out  4  column drive, active-low, exactly one column low
//    button     out  4  encoded key code of the last accepted press
//    bstate     out  1  high while the accepted key is held (debounced)
//    key_valid  out  1  one-cycle pulse in the cycle bstate rises
//    multi_key  out  1  one-cycle pulse after any scan with 2+ keys down
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV       = 1200,
    parameter int DEBOUNCE_SCANS = 50
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] button,
    output logic       bstate,
    output logic       key_valid,
    output logic       multi_key
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DW-1:0] c_div_last = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] c_deb      = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] c_cnt_max  = {CW{1'b1}};
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_PRESS_DEB   = 2'd1;
    localparam logic [1:0] S_HELD        = 2'd2;
    localparam logic [1:0] S_RELEASE_DEB = 2'd3;

    // Keymap indexed by row*4 + col.
    function automatic logic [3:0] f_keymap(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd10;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = 4'd11;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = 4'd12;
            4'd12:   code = 4'd14;
            4'd13:   code = 4'd0;
            4'd14:   code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------------
    // Column scan timing and row synchronizer
    // ------------------------------------------------------------------------
    logic [DW-1:0]     div_q;
    logic [1:0]        col_idx_q;
    logic [3:0]        col_q;
    logic [3:0]        row_s1_q;
    logic [3:0]        row_s2_q;
    // Pressed flags for columns 0..2 of the scan in progress, [col][row].
    logic [2:0][3:0]   keys_q;

    logic              w_sample;
    logic              w_eval;

    // Rows are sampled on the last cycle of each dwell. The synchronizer adds
    // two cycles of latency, which is safe because every dwell is >= 4 cycles.
    assign w_sample = (div_q == c_div_last);
    assign w_eval   = w_sample && (col_idx_q == 2'd3);

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
            row_s1_q  <= 4'hF;
            row_s2_q  <= 4'hF;
            keys_q    <= '0;
        end else begin
            row_s1_q <= row_in;
            row_s2_q <= row_s1_q;
            if (w_sample) begin
                div_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                col_q     <= {col_q[2:0], col_q[3]};
                case (col_idx_q)
                    2'd0:    keys_q[0] <= ~row_s2_q;
                    2'd1:    keys_q[1] <= ~row_s2_q;
                    2'd2:    keys_q[2] <= ~row_s2_q;
                    default: keys_q    <= keys_q;
                endcase
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    assign col_out = col_q;

    // ------------------------------------------------------------------------
    // Scan result classification
    // ------------------------------------------------------------------------
    // Full-keypad picture at evaluation time: stored columns 0..2 plus the
    // column 3 rows being sampled in this very cycle.
    logic [15:0] w_scan;
    logic [4:0]  w_nkeys;
    logic [3:0]  w_idx;
    logic        w_none;
    logic        w_single;
    logic        w_multi;
    logic [3:0]  w_code;

    always_comb begin
        w_scan = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_scan[r*4 + c] = keys_q[c][r];
            end
            w_scan[r*4 + 3] = ~row_s2_q[r];
        end
    end

    always_comb begin
        w_nkeys = '0;
        w_idx   = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_scan[i]) begin
                w_nkeys = w_nkeys + 5'd1;
                w_idx   = 4'(i);
            end
        end
    end

    assign w_none   = (w_nkeys == 5'd0);
    assign w_single = (w_nkeys == 5'd1);
    assign w_multi  = (w_nkeys >= 5'd2);
    assign w_code   = f_keymap(w_idx);

    // ------------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------------
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    button_q, button_d;
    logic          bstate_q, bstate_d;
    logic          key_valid_q, key_valid_d;
    logic          multi_key_q, multi_key_d;

    logic [CW-1:0] w_cnt_inc;
    logic          w_done;
    logic          w_same;

    // Saturating increment; the count that this scan would bring us to.
    assign w_cnt_inc = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + CW'(1);
    assign w_done    = (w_cnt_inc >= c_deb);
    assign w_same    = w_single && (w_code == cand_q);

    // State register
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the FSM only moves at scan evaluation.
    always_comb begin
        state_d = state_q;
        if (w_eval) begin
            case (state_q)
                S_IDLE: begin
                    if (w_single) begin
                        state_d = (DEBOUNCE_SCANS == 1) ? S_HELD : S_PRESS_DEB;
                    end
                end
                S_PRESS_DEB: begin
                    if (w_same) begin
                        state_d = w_done ? S_HELD : S_PRESS_DEB;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (w_none) begin
                        state_d = (DEBOUNCE_SCANS == 1) ? S_IDLE : S_RELEASE_DEB;
                    end
                end
                default: begin
                    if (w_none) begin
                        state_d = w_done ? S_IDLE : S_RELEASE_DEB;
                    end else begin
                        state_d = S_HELD;
                    end
                end
            endcase
        end
    end

    // Output / datapath next values. The counter is cleared on every state
    // entry; entering a debounce state already counts the entering scan as 1.
    always_comb begin
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        button_d    = button_q;
        bstate_d    = bstate_q;
        key_valid_d = 1'b0;
        multi_key_d = w_eval && w_multi;
        if (w_eval) begin
            case (state_q)
                S_IDLE: begin
                    if (w_single) begin
                        cand_d = w_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            button_d    = w_code;
                            bstate_d    = 1'b1;
                            key_valid_d = 1'b1;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = c_cnt_one;
                        end
                    end
                end
                S_PRESS_DEB: begin
                    if (w_same) begin
                        if (w_done) begin
                            button_d    = cand_q;
                            bstate_d    = 1'b1;
                            key_valid_d = 1'b1;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = w_cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                S_HELD: begin
                    // Any key activity while held is ignored for encoding;
                    // button stays put until a full release is debounced.
                    if (w_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            bstate_d = 1'b0;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = c_cnt_one;
                        end
                    end
                end
                default: begin
                    if (w_none) begin
                        if (w_done) begin
                            bstate_d = 1'b0;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = w_cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            cand_q      <= '0;
            button_q    <= '0;
            bstate_q    <= 1'b0;
            key_valid_q <= 1'b0;
            multi_key_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            button_q    <= button_d;
            bstate_q    <= bstate_d;
            key_valid_q <= key_valid_d;
            multi_key_q <= multi_key_d;
        end
    end

    assign button    = button_q;
    assign bstate    = bstate_q;
    assign key_valid = key_valid_q;
    assign multi_key = multi_key_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Directed self-checking bench for keypad_scanner with a small
//             keypad model (pressed[row*4+col] pulls the row low while its
//             column is driven low).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV = 8;
    localparam int DEB      = 3;
    localparam int SCAN     = 4 * SCAN_DIV;

    logic        hwclk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  button;
    logic        bstate;
    logic        key_valid;
    logic        multi_key;

    logic [15:0] pressed = 16'h0000;

    int errors = 0;
    int checks = 0;
    int kv_cnt = 0;
    int kv_base;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .hwclk    (hwclk),
        .reset    (reset),
        .row_in   (row_in),
        .col_out  (col_out),
        .button   (button),
        .bstate   (bstate),
        .key_valid(key_valid),
        .multi_key(multi_key)
    );

    always #5 hwclk = ~hwclk;

    // Keypad model
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
        end
    end

    // Count key_valid pulses (counted at the edge that ends the pulse cycle)
    always @(posedge hwclk) begin
        if (key_valid === 1'b1) kv_cnt <= kv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench #1 after a scan-evaluation edge when started aligned.
    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(posedge hwclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- 1. reset and idle scanning ----
        pressed = 16'h0000;
        reset   = 1'b1;
        #12;
        chk("rst_col_out",   32'(col_out),   32'hE);
        chk("rst_button",    32'(button),    32'h0);
        chk("rst_bstate",    32'(bstate),    32'h0);
        chk("rst_key_valid", 32'(key_valid), 32'h0);
        chk("rst_multi_key", 32'(multi_key), 32'h0);
        @(negedge hwclk);
        reset = 1'b0;
        repeat (SCAN_DIV) @(posedge hwclk);
        #1 chk("col_rot1", 32'(col_out), 32'hD);
        repeat (SCAN_DIV) @(posedge hwclk);
        #1 chk("col_rot2", 32'(col_out), 32'hB);
        repeat (SCAN_DIV) @(posedge hwclk);
        #1 chk("col_rot3", 32'(col_out), 32'h7);
        repeat (SCAN_DIV) @(posedge hwclk);
        #1 chk("col_rot4", 32'(col_out), 32'hE);
        wait_scans(3);
        chk("idle_bstate",    32'(bstate),    32'h0);
        chk("idle_multi_key", 32'(multi_key), 32'h0);

        // ---- 2. hold r1c1 for 10 scans, then release ----
        kv_base = kv_cnt;
        pressed = 16'h0020;
        wait_scans(2);
        chk("t2_bstate_2scans", 32'(bstate), 32'h0);
        wait_scans(1);
        chk("t2_bstate_3scans", 32'(bstate),    32'h1);
        chk("t2_button",        32'(button),    32'h5);
        chk("t2_key_valid",     32'(key_valid), 32'h1);
        wait_scans(7);
        chk("t2_bstate_held", 32'(bstate), 32'h1);
        chk("t2_kv_count",    32'(kv_cnt - kv_base), 32'd1);
        pressed = 16'h0000;
        wait_scans(2);
        chk("t2_rel_2scans", 32'(bstate), 32'h1);
        wait_scans(1);
        chk("t2_rel_3scans",  32'(bstate), 32'h0);
        chk("t2_button_kept", 32'(button), 32'h5);

        // ---- 3. bounce r0c0, then hold ----
        kv_base = kv_cnt;
        for (int k = 0; k < 2; k++) begin
            pressed = 16'h0001;
            wait_scans(1);
            pressed = 16'h0000;
            wait_scans(1);
        end
        chk("t3_bounce_kv",     32'(kv_cnt - kv_base), 32'd0);
        chk("t3_bounce_bstate", 32'(bstate), 32'h0);
        pressed = 16'h0001;
        wait_scans(4);
        chk("t3_bstate", 32'(bstate), 32'h1);
        chk("t3_button", 32'(button), 32'h1);
        chk("t3_kv",     32'(kv_cnt - kv_base), 32'd1);
        pressed = 16'h0000;
        wait_scans(3);
        chk("t3_released", 32'(bstate), 32'h0);

        // ---- 4. multi-key from IDLE, then extra key while HELD ----
        pressed = 16'h0003;
        for (int k = 0; k < 3; k++) begin
            wait_scans(1);
            chk("t4_multi_pulse",  32'(multi_key), 32'h1);
            chk("t4_multi_bstate", 32'(bstate),    32'h0);
        end
        pressed = 16'h0000;
        wait_scans(1);
        chk("t4_none_multi", 32'(multi_key), 32'h0);
        kv_base = kv_cnt;
        pressed = 16'h0100;
        wait_scans(3);
        chk("t4_bstate", 32'(bstate), 32'h1);
        chk("t4_button", 32'(button), 32'h7);
        pressed = 16'h0300;
        wait_scans(1);
        chk("t4_held_multi",  32'(multi_key), 32'h1);
        chk("t4_held_bstate", 32'(bstate),    32'h1);
        wait_scans(1);
        chk("t4_button_kept", 32'(button), 32'h7);
        chk("t4_kv",          32'(kv_cnt - kv_base), 32'd1);
        pressed = 16'h0000;
        wait_scans(3);
        chk("t4_released", 32'(bstate), 32'h0);

        // ---- 5. short release while HELD on r3c1 ----
        kv_base = kv_cnt;
        pressed = 16'h2000;
        wait_scans(3);
        chk("t5_bstate", 32'(bstate), 32'h1);
        chk("t5_button", 32'(button), 32'h0);
        pressed = 16'h0000;
        wait_scans(1);
        chk("t5_gap1", 32'(bstate), 32'h1);
        wait_scans(1);
        chk("t5_gap2", 32'(bstate), 32'h1);
        pressed = 16'h2000;
        wait_scans(1);
        chk("t5_repress", 32'(bstate), 32'h1);
        wait_scans(2);
        chk("t5_still_held", 32'(bstate), 32'h1);
        chk("t5_kv",         32'(kv_cnt - kv_base), 32'd1);
        pressed = 16'h0000;
        wait_scans(3);
        chk("t5_released", 32'(bstate), 32'h0);

        // ---- 6. reset while HELD on r2c2 ----
        pressed = 16'h0400;
        wait_scans(3);
        chk("t6_bstate", 32'(bstate), 32'h1);
        chk("t6_button", 32'(button), 32'h9);
        @(negedge hwclk);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_bstate",  32'(bstate),  32'h0);
        chk("t6_rst_button",  32'(button),  32'h0);
        chk("t6_rst_col_out", 32'(col_out), 32'hE);
        repeat (3) @(posedge hwclk);
        @(negedge hwclk);
        reset = 1'b0;
        wait_scans(2);
        chk("t6_post_2scans", 32'(bstate), 32'h0);
        wait_scans(1);
        chk("t6_post_bstate", 32'(bstate),    32'h1);
        chk("t6_post_button", 32'(button),    32'h9);
        chk("t6_post_kv",     32'(key_valid), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
